// File: rtl/debounce_pkg.sv
// Shared types and board constants for the switch debouncer and its helpers.
package debounce_pkg;

  localparam int CLK_HZ      = 100000000;
  localparam int DEBOUNCE_MS = 10;

  // Stability window in clock cycles at the board clock.
  localparam int DEFAULT_CNT_MAX = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// Pin-side and consumer-side signals of one debounced input.
// DEBOUNCE_TOGGLE_EN adds the push-button latch output O_P_LED_TOGGLE.
interface switch_debouncer_if;

  logic I_P_A;
  logic O_P_LED_A;
  logic O_P_RISE;
  logic O_P_FALL;
  logic O_P_BUSY;
`ifdef DEBOUNCE_TOGGLE_EN
  logic O_P_LED_TOGGLE;
`endif

  // Board / consumer side: drives the raw pin, observes the conditioned outputs.
  modport master (
    output I_P_A,
`ifdef DEBOUNCE_TOGGLE_EN
    input  O_P_LED_TOGGLE,
`endif
    input  O_P_LED_A,
    input  O_P_RISE,
    input  O_P_FALL,
    input  O_P_BUSY
  );

  // Debouncer side.
  modport slave (
    input  I_P_A,
`ifdef DEBOUNCE_TOGGLE_EN
    output O_P_LED_TOGGLE,
`endif
    output O_P_LED_A,
    output O_P_RISE,
    output O_P_FALL,
    output O_P_BUSY
  );

endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage chain;
  // blocking ones would collapse it into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces one raw board pin into a clean level plus rise/fall strobes.
// Optional DEBOUNCE_TOGGLE_EN adds a latch output flipped by each accepted press.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter  int CNT_MAX = DEFAULT_CNT_MAX,
  localparam int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic               I_P_CLK,
  input  logic               I_P_RST,
  switch_debouncer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             led_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  sync_2ff u_sync (
    .clk (I_P_CLK),
    .rst (I_P_RST),
    .d   (bus.I_P_A),
    .q   (s)
  );

  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      state  <= STABLE_LOW;
      cnt    <= '0;
      led_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      // Strobes default low so each acceptance yields exactly one cycle.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            state  <= WAIT_HIGH;
            cnt    <= CNT_ONE;
            busy_q <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state  <= STABLE_LOW;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= STABLE_HIGH;
            cnt    <= '0;
            led_q  <= 1'b1;
            rise_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state  <= WAIT_LOW;
            cnt    <= CNT_ONE;
            busy_q <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state  <= STABLE_HIGH;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= STABLE_LOW;
            cnt    <= '0;
            led_q  <= 1'b0;
            fall_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= STABLE_LOW;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_P_LED_A = led_q;
  assign bus.O_P_RISE  = rise_q;
  assign bus.O_P_FALL  = fall_q;
  assign bus.O_P_BUSY  = busy_q;

`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      toggle_q <= 1'b0;
    end else if (rise_q) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign bus.O_P_LED_TOGGLE = toggle_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with CNT_MAX = 8.
// Define DEBOUNCE_TOGGLE_EN to also exercise the toggle latch output.
module tb_switch_debouncer;

  localparam int CNT_MAX = 8;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  switch_debouncer_if bus ();

  switch_debouncer #(.CNT_MAX(CNT_MAX)) dut (
    .I_P_CLK (clk),
    .I_P_RST (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe state one time unit after the rising edge, then drive the next inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {bus.O_P_LED_A, bus.O_P_RISE, bus.O_P_FALL, bus.O_P_BUSY};
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    bus.I_P_A = 1'b0;
    tick();
    tick();
    got = obs();
    total_cnt++;
    if (got !== 4'b0000)
      $display("FAIL reset_state got={led,rise,fall,busy}=%b exp=0000", got);
    else
      pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_idle_low();
    logic [3:0] got;
    bus.I_P_A = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      got = obs();
      total_cnt++;
      if (got !== 4'b0000)
        $display("FAIL idle_low k=%0d got=%b exp=0000", k, got);
      else
        pass_cnt++;
    end
  endtask

  // Pin driven high just after edge t; k counts edges after t.
  task automatic test_clean_rise();
    logic [3:0] got, exp;
    bus.I_P_A = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      got = obs();
      exp = {k >= 10, k == 10, 1'b0, (k >= 3 && k <= 9)};
      total_cnt++;
      if (got !== exp)
        $display("FAIL clean_rise k=%0d got=%b exp=%b", k, got, exp);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_clean_fall();
    logic [3:0] got, exp;
    bus.I_P_A = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      got = obs();
      exp = {k < 10, 1'b0, k == 10, (k >= 3 && k <= 9)};
      total_cnt++;
      if (got !== exp)
        $display("FAIL clean_fall k=%0d got=%b exp=%b", k, got, exp);
      else
        pass_cnt++;
    end
  endtask

  // 1,0,1,0 for 3 cycles each, then steady 1 from iteration 12 onward.
  task automatic test_bounce();
    logic [2:0] got, exp;
    int rises;
    rises = 0;
    for (int i = 0; i < 26; i++) begin
      bus.I_P_A = (i >= 12) ? 1'b1 : (((i / 3) % 2) == 0);
      tick();
      if (bus.O_P_RISE === 1'b1) rises++;
      got = {bus.O_P_LED_A, bus.O_P_RISE, bus.O_P_FALL};
      exp = {i >= 21, i == 21, 1'b0};
      total_cnt++;
      if (got !== exp)
        $display("FAIL bounce i=%0d got=%b exp=%b", i, got, exp);
      else
        pass_cnt++;
    end
    total_cnt++;
    if (rises !== 1)
      $display("FAIL bounce_rise_count got=%0d exp=1", rises);
    else
      pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [2:0] got;
    for (int i = 0; i < 20; i++) begin
      bus.I_P_A = !(i < 5);
      tick();
      got = {bus.O_P_LED_A, bus.O_P_RISE, bus.O_P_FALL};
      total_cnt++;
      if (got !== 3'b100)
        $display("FAIL glitch i=%0d got=%b exp=100", i, got);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_qual();
    logic [3:0] got, exp;
    rst = 1'b1;
    bus.I_P_A = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    bus.I_P_A = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    // Counter now holds 5 inside WAIT_HIGH.
    got = obs();
    total_cnt++;
    if (got !== 4'b0001)
      $display("FAIL mid_qual_busy got=%b exp=0001", got);
    else
      pass_cnt++;
    rst = 1'b1;
    tick();
    got = obs();
    total_cnt++;
    if (got !== 4'b0000)
      $display("FAIL mid_qual_reset got=%b exp=0000", got);
    else
      pass_cnt++;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = obs();
      exp = {k >= 10, k == 10, 1'b0, (k >= 3 && k <= 9)};
      total_cnt++;
      if (got !== exp)
        $display("FAIL mid_qual_requal k=%0d got=%b exp=%b", k, got, exp);
      else
        pass_cnt++;
    end
  endtask

`ifdef DEBOUNCE_TOGGLE_EN
  task automatic test_toggle();
    logic exp;
    rst = 1'b1;
    bus.I_P_A = 1'b0;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (bus.O_P_LED_TOGGLE !== 1'b0)
      $display("FAIL toggle_reset got=%b exp=0", bus.O_P_LED_TOGGLE);
    else
      pass_cnt++;
    for (int p = 0; p < 3; p++) begin
      bus.I_P_A = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        tick();
        exp = (k >= 11) ? ((p + 1) % 2 == 1) : (p % 2 == 1);
        total_cnt++;
        if (bus.O_P_LED_TOGGLE !== exp)
          $display("FAIL toggle_press p=%0d k=%0d got=%b exp=%b", p, k, bus.O_P_LED_TOGGLE, exp);
        else
          pass_cnt++;
      end
      bus.I_P_A = 1'b0;
      for (int k = 1; k <= 14; k++) begin
        tick();
        exp = ((p + 1) % 2 == 1);
        total_cnt++;
        if (bus.O_P_LED_TOGGLE !== exp)
          $display("FAIL toggle_release p=%0d k=%0d got=%b exp=%b", p, k, bus.O_P_LED_TOGGLE, exp);
        else
          pass_cnt++;
      end
    end
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    bus.I_P_A = 1'b0;
    test_reset();
    test_idle_low();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_glitch();
    test_reset_mid_qual();
`ifdef DEBOUNCE_TOGGLE_EN
    test_toggle();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
